ysyx_23060240_ifu: RTL and testbench

- Instruction fetch unit directly upstream of the fetch port of the memory stage; owns the architectural PC.
- Replaces the combinational same-cycle instruction read with a multi-cycle request/response fetch to instruction memory.
- Hands each fetched word to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from execute and discards any stale in-flight fetch.

---
 rtl/ysyx_23060240_ifu_if.sv | 33 +++
 rtl/ysyx_23060240_ifu.sv | 106 ++++++++++
 tb/tb_ysyx_23060240_ifu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060240_ifu_if.sv
// ysyx_23060240_ifu_if: fetch-unit bundle covering the memory request/response
// channel, the decode-side instruction handshake and the execute redirect.
//   master (IFU side): drives req_valid/req_addr and inst_valid/inst/inst_pc/inst_fault
//   slave  (memory, decode, execute): drives req_ready, resp_*, inst_ready, redirect_*
interface ysyx_23060240_ifu_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
        input  req_ready, resp_valid, resp_data, resp_err, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
        output req_ready, resp_valid, resp_data, resp_err, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_23060240_ifu.sv
// ysyx_23060240_ifu: instruction fetch unit owning the PC; issues one fetch at a
// time to instruction memory and hands each word to decode, honouring redirects.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ysyx_23060240_ifu_if.master (request, response, inst and redirect)
module ysyx_23060240_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    ysyx_23060240_ifu_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            drop;
    logic            pend;
    logic            req_valid;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;
    logic [XLEN-1:0] rpc;

    assign rpc            = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign bus.req_valid  = req_valid;
    assign bus.req_addr   = pc;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst;
    assign bus.inst_pc    = inst_pc;
    assign bus.inst_fault = inst_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= XLEN'(RESET_PC);
            tgt        <= '0;
            drop       <= 1'b0;
            pend       <= 1'b0;
            req_valid  <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid) pc <= rpc;
                    state     <= REQ;
                    req_valid <= 1'b1;
                end
                REQ: begin
                    if (bus.req_ready) begin
                        // The request leaves with the old address; any redirect
                        // seen now or held back turns its response into a drop.
                        state     <= WAIT;
                        req_valid <= 1'b0;
                        pend      <= 1'b0;
                        if (bus.redirect_valid) begin
                            pc   <= rpc;
                            drop <= 1'b1;
                        end else if (pend) begin
                            pc   <= tgt;
                            drop <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        // req_addr must not move while the request is unaccepted.
                        pend <= 1'b1;
                        tgt  <= rpc;
                    end
                end
                WAIT: begin
                    if (bus.resp_valid) begin
                        if (drop || bus.redirect_valid) begin
                            if (bus.redirect_valid) pc <= rpc;
                            drop      <= 1'b0;
                            state     <= REQ;
                            req_valid <= 1'b1;
                        end else begin
                            inst       <= bus.resp_data;
                            inst_pc    <= pc;
                            inst_fault <= bus.resp_err;
                            state      <= HOLD;
                            inst_valid <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        pc   <= rpc;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        pc         <= bus.redirect_valid ? rpc : pc + XLEN'(4);
                        state      <= REQ;
                        inst_valid <= 1'b0;
                        req_valid  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// tb_ysyx_23060240_ifu: directed self-checking bench for the fetch unit.
module tb_ysyx_23060240_ifu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_23060240_ifu_if #(.XLEN(32)) bus ();

    ysyx_23060240_ifu #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: request accepted, response next cycle, decode stalls
    // for `hold` cycles, then consumes.
    task automatic fetch(input logic [31:0] data, input logic err,
                         input logic [31:0] addr, input int hold);
        check("req_valid", 32'(bus.req_valid), 32'd1);
        check("req_addr", bus.req_addr, addr);
        bus.req_ready = 1'b1;
        tick;
        bus.req_ready = 1'b0;
        check("wait_req_valid", 32'(bus.req_valid), 32'd0);
        bus.resp_valid = 1'b1;
        bus.resp_data  = data;
        bus.resp_err   = err;
        tick;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i <= hold; i++) begin
            check("inst_valid", 32'(bus.inst_valid), 32'd1);
            check("inst", bus.inst, data);
            check("inst_pc", bus.inst_pc, addr);
            check("inst_fault", 32'(bus.inst_fault), 32'(err));
            check("hold_no_req", 32'(bus.req_valid), 32'd0);
            if (i < hold) tick;
        end
        bus.inst_ready = 1'b1;
        tick;
        bus.inst_ready = 1'b0;
        check("inst_valid_drop", 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = '0;
        bus.resp_err       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #12;
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_req_addr", bus.req_addr, 32'h8000_0000);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        fetch(32'h0000_0413, 1'b0, 32'h8000_0000, 0);
        check("next_addr", bus.req_addr, 32'h8000_0004);

        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_req_valid", 32'(bus.req_valid), 32'd1);
            check("bp_req_addr", bus.req_addr, 32'h8000_0004);
        end
        fetch(32'h0010_0093, 1'b0, 32'h8000_0004, 4);

        fetch(32'h0000_0013, 1'b1, 32'h8000_0008, 0);
        fetch(32'h0020_0113, 1'b0, 32'h8000_000C, 0);

        // Redirect while waiting for the response.
        bus.req_ready = 1'b1;
        tick;
        bus.req_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick;
        bus.redirect_valid = 1'b0;
        bus.resp_valid     = 1'b1;
        bus.resp_data      = 32'hDEAD_BEEF;
        tick;
        bus.resp_valid = 1'b0;
        check("wait_rd_no_inst", 32'(bus.inst_valid), 32'd0);
        fetch(32'h0000_0011, 1'b0, 32'h8000_0100, 0);

        // Redirect while the request is still unaccepted.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick;
        bus.redirect_valid = 1'b0;
        tick;
        check("req_rd_addr_stable", bus.req_addr, 32'h8000_0104);
        check("req_rd_valid", 32'(bus.req_valid), 32'd1);
        bus.req_ready = 1'b1;
        tick;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'hDEAD_BEEF;
        tick;
        bus.resp_valid = 1'b0;
        check("req_rd_no_inst", 32'(bus.inst_valid), 32'd0);
        fetch(32'h0000_0022, 1'b0, 32'h8000_0200, 0);

        // Redirect in HOLD together with inst_ready.
        bus.req_ready = 1'b1;
        tick;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0055;
        tick;
        bus.resp_valid = 1'b0;
        check("hold_inst_pc", bus.inst_pc, 32'h8000_0204);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0040;
        tick;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        check("hold_rd_inst_valid", 32'(bus.inst_valid), 32'd0);
        fetch(32'h0000_0066, 1'b0, 32'h8000_0040, 0);

        // Misaligned redirect to the top of memory, then wrap.
        bus.req_ready = 1'b1;
        tick;
        bus.req_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick;
        bus.redirect_valid = 1'b0;
        bus.resp_valid     = 1'b1;
        tick;
        bus.resp_valid = 1'b0;
        fetch(32'h0000_0033, 1'b0, 32'hFFFF_FFFC, 0);
        check("wrap_addr", bus.req_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of a request.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("async_rst_addr", bus.req_addr, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
